// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int OHT_MAX_W   = 64;
    localparam int OHT_MAX_IDX = 6;

    // One-hot to binary index. Each set bit ORs its index in, so the result
    // is exact for a one-hot input and zero for an all-zero input.
    function automatic logic [OHT_MAX_IDX-1:0] oht2bin(input logic [OHT_MAX_W-1:0] oht);
        logic [OHT_MAX_IDX-1:0] idx;
        idx = '0;
        for (int i = 0; i < OHT_MAX_W; i++) begin
            if (oht[i]) begin
                idx = idx | OHT_MAX_IDX'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pry2oht_base.sv
// Priority vector to one-hot: keeps only the highest-priority set bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module pry2oht_base #(
    parameter int    WIDTH          = 8,
    parameter string DIRECTION      = "LSB",
    parameter int    IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht
);

    logic [WIDTH-1:0] vin;
    logic [WIDTH-1:0] vout;

    // MSB priority is handled by bit-reversing around the LSB core.
    generate
        if (DIRECTION == "MSB") begin : g_msb
            for (genvar i = 0; i < WIDTH; i++) begin : g_rev
                assign vin[i]             = pry[WIDTH-1-i];
                assign oht[WIDTH-1-i]     = vout[i];
            end
        end else begin : g_lsb
            assign vin = pry;
            assign oht = vout;
        end
    endgenerate

    generate
        if (IMPLEMENTATION == 1) begin : g_vec
            // Clearing everything above the lowest set bit via borrow.
            assign vout = vin & ~(vin - WIDTH'(1));
        end else if (IMPLEMENTATION == 2) begin : g_add
            // Two's complement isolate: x & -x.
            assign vout = vin & (~vin + WIDTH'(1));
        end else begin : g_loop
            // Scan upward and keep the first set bit found.
            always_comb begin
                logic found;
                found = 1'b0;
                vout  = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (vin[i] && !found) begin
                        vout[i] = 1'b1;
                        found   = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/arb_rr_reg.sv
// Registered round-robin arbiter; grant held until ack releases it.
// Latency: request in cycle N gives gnt_vld in N+1; ack with pending req re-grants back-to-back.
// Backpressure: grant is frozen while ack=0, even if the granted req bit drops.
module arb_rr_reg
    import arb_pkg::*;
#(
    parameter int  WIDTH          = 8,
    parameter int  IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    input  logic                 ack,
    output logic [WIDTH-1:0]     gnt,
    output logic [WIDTH_LOG-1:0] gnt_idx,
    output logic                 gnt_vld
);

    arb_state_t           state_q, state_d;
    logic [WIDTH-1:0]     gnt_q, gnt_d;
    logic [WIDTH_LOG-1:0] idx_q, idx_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;

    logic [WIDTH-1:0]     mask;
    logic [WIDTH-1:0]     msk;
    logic [WIDTH-1:0]     msk_oht;
    logic [WIDTH-1:0]     req_oht;
    logic [WIDTH-1:0]     cand;
    logic [WIDTH_LOG-1:0] cand_idx;
    logic                 cand_vld;

    // Only requesters strictly above the last grant get first pick this round.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i > int'(ptr_q));
        end
    end

    assign msk = req & mask;

    pry2oht_base #(
        .WIDTH          (WIDTH),
        .DIRECTION      ("LSB"),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pry_msk (
        .pry (msk),
        .oht (msk_oht)
    );

    pry2oht_base #(
        .WIDTH          (WIDTH),
        .DIRECTION      ("LSB"),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pry_req (
        .pry (req),
        .oht (req_oht)
    );

    // Empty masked set means wrap: the lowest requester overall wins.
    assign cand     = (|msk) ? msk_oht : req_oht;
    assign cand_vld = |req;
    assign cand_idx = WIDTH_LOG'(oht2bin(OHT_MAX_W'(cand)));

    // Next-state: load on new arbitration, hold while unacknowledged, drain on ack with no requests.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (cand_vld) begin
                gnt_d   = cand;
                idx_d   = cand_idx;
                ptr_d   = cand_idx;
                state_d = GRANT;
            end
        end else begin
            if (ack) begin
                if (cand_vld) begin
                    gnt_d = cand;
                    idx_d = cand_idx;
                    ptr_d = cand_idx;
                end else begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    // State, grant and pointer registers; pointer resets to the top so index 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= WIDTH_LOG'(WIDTH - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = (state_q == GRANT);

endmodule

// File: tb/tb_arb_rr_reg.sv
// Bench for arb_rr_reg: directed scenarios plus random traffic against a rotating-search model.
// Latency: model updates on each rising edge, outputs compared 1 time unit later.
// Backpressure: ack driven by the bench; model holds grant while ack is low.
module tb_arb_rr_reg;

    localparam int W  = 8;
    localparam int WL = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  req   = '0;
    logic          ack   = 1'b0;
    logic [W-1:0]  gnt;
    logic [WL-1:0] gnt_idx;
    logic          gnt_vld;

    int total = 0;
    int bad   = 0;

    // Reference model state: last granted index, active flag, current grant index.
    int m_ptr = W - 1;
    int m_idx = 0;
    bit m_vld = 1'b0;

    arb_rr_reg #(
        .WIDTH          (W),
        .IMPLEMENTATION (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (ack),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin: walk from the requester after the last grant, wrapping around.
    function automatic int rr_pick(input int p, input logic [W-1:0] r);
        for (int k = 1; k <= W; k++) begin
            int j;
            j = (p + k) % W;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_ptr = W - 1;
        m_idx = 0;
        m_vld = 1'b0;
    endtask

    task automatic model_clock();
        if (!m_vld) begin
            if (req != '0) begin
                m_idx = rr_pick(m_ptr, req);
                m_ptr = m_idx;
                m_vld = 1'b1;
            end
        end else if (ack) begin
            if (req != '0) begin
                m_idx = rr_pick(m_ptr, req);
                m_ptr = m_idx;
            end else begin
                m_idx = 0;
                m_vld = 1'b0;
            end
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_clock();
        else       model_reset();
        #1;
        chk({tag, ".vld"}, 64'(gnt_vld), 64'(m_vld));
        chk({tag, ".idx"}, 64'(gnt_idx), 64'(m_idx));
        chk({tag, ".gnt"}, 64'(gnt), m_vld ? (64'(1) << m_idx) : 64'(0));
    endtask

    task automatic expect_grant(input string tag, input int idx);
        chk({tag, ".cvld"}, 64'(gnt_vld), 64'(1));
        chk({tag, ".cidx"}, 64'(gnt_idx), 64'(idx));
        chk({tag, ".cgnt"}, 64'(gnt), 64'(1) << idx);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".cvld"}, 64'(gnt_vld), 64'(0));
        chk({tag, ".cidx"}, 64'(gnt_idx), 64'(0));
        chk({tag, ".cgnt"}, 64'(gnt), 64'(0));
    endtask

    initial begin
        // Reset state.
        #12;
        expect_idle("reset");
        rst_n = 1'b1;

        // Single request, held through 5 cycles without ack (req dropped too).
        req = 8'b0001_0000; ack = 1'b0;
        step("single");
        expect_grant("single", 4);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            step("hold");
            expect_grant("hold", 4);
        end

        // Park the pointer on 7, then full fairness rotation 0..7,0.
        req = 8'h80; ack = 1'b1;
        step("park7");
        expect_grant("park7", 7);
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step("rot");
            expect_grant("rot", i % 8);
        end

        // Wrap and skip from ptr=5.
        req = 8'b0010_0000;
        step("to5");
        expect_grant("to5", 5);
        req = 8'b0010_0101;
        step("wrap");
        expect_grant("wrap", 0);
        step("skip");
        expect_grant("skip", 2);

        // Sole re-request.
        req = 8'b0000_1000;
        step("sole");
        expect_grant("sole", 3);
        ack = 1'b0;
        step("sole_hold");
        expect_grant("sole_hold", 3);
        ack = 1'b1;
        step("sole_re");
        expect_grant("sole_re", 3);

        // Drain to idle from a grant on bit 7; pointer stays on 7.
        req = 8'h80;
        step("d7");
        expect_grant("d7", 7);
        req = '0;
        step("drain");
        expect_idle("drain");
        req = 8'b1000_0001; ack = 1'b0;
        step("after_drain");
        expect_grant("after_drain", 0);

        // Asynchronous reset between edges while granting.
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("arst");
        model_reset();
        #1;
        rst_n = 1'b1;
        req = 8'hF0;
        step("post_rst");
        expect_grant("post_rst", 4);

        // Random traffic: mix of dense, sparse and empty request vectors.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       req = W'($urandom);
                1:       req = W'($urandom) & W'($urandom);
                2:       req = W'(1) << $urandom_range(0, W - 1);
                default: req = '0;
            endcase
            ack = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
